hevc_idct4_mac_engine: RTL and testbench

- Inverse-direction counterpart of the HEVC forward-DCT MAC datapath.
- Accepts one 4-point vector of transform coefficients serially and reconstructs 4 residual samples with a single 16x8 signed MAC.
- Each output is rounded, shifted and clipped before it leaves the block.
- Sits after dequantisation in the inverse-transform path and serves as the per-row/per-column 1-D IDCT stage.

---
 rtl/hevc_idct4_mac_engine.sv | 211 +++++++++++++++++++++
 tb/tb_hevc_idct4_mac_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_idct4_mac_engine.sv
// 4-point HEVC inverse DCT, one 16x8 signed MAC; serial coefficients in, rounded/clipped samples out.
// Optional build macro HEVC_IDCT_CLIP_FLAG_EN adds clip_flag / clip_seen status outputs.
module hevc_idct4_mac_engine #(
  parameter int SHIFT = 7,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_idx,
`ifdef HEVC_IDCT_CLIP_FLAG_EN
  output logic                    clip_flag,
  output logic                    clip_seen,
`endif
  output logic                    out_last
);

  typedef enum logic [1:0] {LOAD, MAC, ROUND, OUT} state_t;

  localparam logic signed [31:0] RND     = 32'sd1 <<< (SHIFT - 1);
  localparam logic signed [31:0] OUT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] OUT_MIN = -(32'sd1 <<< (OUT_W - 1));

  function automatic logic signed [7:0] m_coef(input logic [1:0] k, input logic [1:0] n);
    logic signed [7:0] m;
    case ({k, n})
      4'b00_00, 4'b00_01, 4'b00_10, 4'b00_11: m = 8'sd64;
      4'b01_00: m = 8'sd83;
      4'b01_01: m = 8'sd36;
      4'b01_10: m = -8'sd36;
      4'b01_11: m = -8'sd83;
      4'b10_00: m = 8'sd64;
      4'b10_01: m = -8'sd64;
      4'b10_10: m = -8'sd64;
      4'b10_11: m = 8'sd64;
      4'b11_00: m = 8'sd36;
      4'b11_01: m = -8'sd83;
      4'b11_10: m = 8'sd83;
      default:  m = -8'sd36;
    endcase
    return m;
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              n_q, n_d;
  logic [1:0]              k_q, k_d;
  logic signed [31:0]      acc_q, acc_d;
  logic signed [15:0]      coef_q [4];
  logic signed [15:0]      coef_d [4];
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [1:0]              out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
  logic                    clip_flag_q, clip_flag_d;
  logic                    clip_seen_q, clip_seen_d;
`endif

  logic signed [7:0]       m_sel;
  logic signed [15:0]      c_sel;
  logic signed [23:0]      prod;
  logic signed [31:0]      rnd_sum;
  logic signed [31:0]      shifted;
  logic                    sat_hi, sat_lo;
  logic signed [OUT_W-1:0] sample;

  // Sign-extended operands make the low 24 product bits exact.
  always_comb begin
    m_sel   = m_coef(k_q, n_q);
    c_sel   = coef_q[k_q];
    prod    = {{16{m_sel[7]}}, m_sel} * {{8{c_sel[15]}}, c_sel};
    rnd_sum = acc_q + RND;
    shifted = rnd_sum >>> SHIFT;
    sat_hi  = shifted > OUT_MAX;
    sat_lo  = shifted < OUT_MIN;
    if (sat_hi)      sample = OUT_MAX[OUT_W-1:0];
    else if (sat_lo) sample = OUT_MIN[OUT_W-1:0];
    else             sample = shifted[OUT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
    clip_flag_d = clip_flag_q;
    clip_seen_d = clip_seen_q;
`endif

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          coef_d[cnt_q] = in_coef;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = MAC;
            n_d     = 2'd0;
            k_d     = 2'd0;
            acc_d   = '0;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + {{8{prod[23]}}, prod};
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ROUND;
      end
      ROUND: begin
        out_data_d  = sample;
        out_idx_d   = n_q;
        out_last_d  = (n_q == 2'd3);
        out_valid_d = 1'b1;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
        clip_flag_d = sat_hi | sat_lo;
        clip_seen_d = clip_seen_q | sat_hi | sat_lo;
`endif
        state_d     = OUT;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
          clip_flag_d = 1'b0;
`endif
          if (n_q != 2'd3) begin
            n_d     = n_q + 2'd1;
            k_d     = 2'd0;
            state_d = MAC;
          end else begin
            cnt_d   = 2'd0;
            state_d = LOAD;
          end
        end
      end
    endcase

    // Abort overrides any handshake taken above on the same edge.
    if (flush) begin
      state_d     = LOAD;
      cnt_d       = 2'd0;
      n_d         = 2'd0;
      k_d         = 2'd0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
      clip_flag_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < 4; i++) coef_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
      clip_flag_q <= 1'b0;
      clip_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
      clip_flag_q <= clip_flag_d;
      clip_seen_q <= clip_seen_d;
`endif
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
  assign clip_flag = clip_flag_q;
  assign clip_seen = clip_seen_q;
`endif

endmodule

// File: tb/tb_hevc_idct4_mac_engine.sv
// Testbench for hevc_idct4_mac_engine: directed and randomized vectors against an arithmetic IDCT model.
module tb_hevc_idct4_mac_engine;

  localparam int SHIFT = 7;
  localparam int OUT_W = 16;
  localparam int MAT [4][4] = '{'{64, 64, 64, 64},
                                '{83, 36, -36, -83},
                                '{64, -64, -64, 64},
                                '{36, -83, 83, -36}};

  typedef int vec_t [4];

  logic                    clk = 1'b0;
  logic                    reset, flush, in_valid, in_ready;
  logic signed [15:0]      in_coef;
  logic                    out_valid, out_ready, out_last;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_idx;
`ifdef HEVC_IDCT_CLIP_FLAG_EN
  logic                    clip_flag, clip_seen;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit model_seen = 1'b0;

  always #5 clk = ~clk;

  hevc_idct4_mac_engine #(.SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
`ifdef HEVC_IDCT_CLIP_FLAG_EN
    .clip_flag(clip_flag), .clip_seen(clip_seen),
`endif
    .out_last(out_last)
  );

  function automatic int ref_raw(input vec_t c, input int n);
    longint sum = 0;
    for (int k = 0; k < 4; k++) sum += longint'(MAT[k][n]) * longint'(c[k]);
    sum = (sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    return int'(sum);
  endfunction

  function automatic int ref_clip(input int v);
    int hi = (1 << (OUT_W - 1)) - 1;
    int lo = -(1 << (OUT_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic push_vec(input vec_t c);
    for (int i = 0; i < 4; i++) begin
      int w = 0;
      in_valid = 1'b1;
      in_coef  = 16'(c[i]);
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) begin
        n_checks++; n_fail++;
        $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Receives `count` samples; sample stall_n is held off for stall_len cycles.
  task automatic recv_vec(input vec_t c, input int count, input int stall_n,
                          input int stall_len, input bit pulse, input string tag);
    for (int n = 0; n < count; n++) begin
      int cyc = 0;
      int raw, exp_v;
      logic signed [OUT_W-1:0] held_d;
      logic [1:0] held_i;
      out_ready = 1'b0;
      while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != 5) begin
        n_fail++;
        $display("FAIL %s_latency n=%0d: got %0d cycles, required 5", tag, n, cyc);
      end
      raw   = ref_raw(c, n);
      exp_v = ref_clip(raw);
      if (n == stall_n) begin
        held_d = out_data;
        held_i = out_idx;
        for (int s = 0; s < stall_len; s++) begin
          in_valid = pulse && (s % 2 == 0);
          in_coef  = 16'sh1234;
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== held_d || out_idx !== held_i || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stall s=%0d: vld=%0b data=%0d idx=%0d rdy=%0b, required 1/%0d/%0d/0",
                     tag, s, out_valid, out_data, out_idx, in_ready, held_d, held_i);
          end
        end
        in_valid = 1'b0;
      end
      n_checks++;
      if (out_data !== OUT_W'(exp_v)) begin
        n_fail++;
        $display("FAIL %s_data n=%0d: got %0d, required %0d", tag, n, out_data, exp_v);
      end
      n_checks++;
      if (out_idx !== 2'(n) || out_last !== (n == 3)) begin
        n_fail++;
        $display("FAIL %s_idx n=%0d: got idx=%0d last=%0b, required idx=%0d last=%0b",
                 tag, n, out_idx, out_last, n, (n == 3));
      end
`ifdef HEVC_IDCT_CLIP_FLAG_EN
      model_seen = model_seen | (raw != exp_v);
      n_checks++;
      if (clip_flag !== (raw != exp_v) || clip_seen !== model_seen) begin
        n_fail++;
        $display("FAIL %s_clip n=%0d: got flag=%0b seen=%0b, required flag=%0b seen=%0b",
                 tag, n, clip_flag, clip_seen, (raw != exp_v), model_seen);
      end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_coef = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b vld=%0b data=%0d idx=%0d last=%0b, required 1/0/0/0/0",
               in_ready, out_valid, out_data, out_idx, out_last);
    end
  endtask

  task automatic test_basic();
    vec_t a = '{64, 0, 0, 0};
    vec_t b = '{0, 128, 0, 0};
    push_vec(a); recv_vec(a, 4, -1, 0, 1'b0, "dc");
    push_vec(b); recv_vec(b, 4, -1, 0, 1'b0, "k1");
  endtask

  task automatic test_clip();
    vec_t a = '{32767, 32767, 32767, 32767};
    vec_t b = '{-32768, -32768, -32768, -32768};
    push_vec(a); recv_vec(a, 4, -1, 0, 1'b0, "clip_pos");
    push_vec(b); recv_vec(b, 4, -1, 0, 1'b0, "clip_neg");
  endtask

  task automatic test_backpressure();
    vec_t a = '{100, -200, 300, -50};
    vec_t b = '{5, 17, -9, 1000};
    push_vec(a); recv_vec(a, 4, 1, 6, 1'b1, "bp");
    push_vec(b); recv_vec(b, 4, -1, 0, 1'b0, "bp_after");
  endtask

  task automatic test_flush();
    vec_t a = '{1000, 2000, -3000, 400};
    vec_t b = '{64, 0, 0, 0};
    push_vec(a);
    recv_vec(a, 2, -1, 0, 1'b0, "pre_flush");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: rdy=%0b vld=%0b, required 1/0", in_ready, out_valid);
    end
    push_vec(b); recv_vec(b, 4, -1, 0, 1'b0, "post_flush");
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      vec_t c;
      logic signed [15:0] t;
      for (int i = 0; i < 4; i++) begin
        t = 16'($urandom);
        c[i] = (j < 4) ? (int'(t) >>> 6) : int'(t);
      end
      push_vec(c);
      recv_vec(c, 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, "rand");
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    vec_t a = '{-7, 900, 12, -31000};
    push_vec(a);
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_seen = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%0b vld=%0b data=%0d idx=%0d last=%0b, required 1/0/0/0/0",
               in_ready, out_valid, out_data, out_idx, out_last);
    end
`ifdef HEVC_IDCT_CLIP_FLAG_EN
    n_checks++;
    if (clip_flag !== 1'b0 || clip_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clip: flag=%0b seen=%0b, required 0/0", clip_flag, clip_seen);
    end
`endif
    for (int j = 0; j < 3; j++) begin
      vec_t c;
      logic signed [15:0] t;
      for (int i = 0; i < 4; i++) begin t = 16'($urandom); c[i] = int'(t); end
      push_vec(c);
      recv_vec(c, 4, -1, 0, 1'b0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_backpressure();
    test_flush();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
